fpu_sp_f2i: RTL and testbench

FPU_SP_F2I -- requirements
Module: fpu_sp_f2i

---
 rtl/fpu_sp_f2i.sv | 150 +++++++++++++++
 tb/tb_fpu_sp_f2i.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_sp_f2i.sv
// fpu_sp_f2i: IEEE-754 single-precision to signed 32-bit integer converter.
// Multi-cycle FSM: unpack, shift right one bit per cycle up to the integer
// point, round, negate, present. NaN/overflow/tiny inputs bypass the shifter.
// Rounding mode selected at build time by macro FPU_F2I_RNE_EN:
//   defined   -> round to nearest, ties to even
//   undefined -> truncate toward zero
module fpu_sp_f2i (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        dval,
  output logic [31:0] result,
  output logic        rdy,
  output logic        nv
);

`ifdef FPU_F2I_RNE_EN
  localparam bit              RNE_MODE = 1'b1;
  // 0.5 <= |x| < 1 can still round up to 1, so only e < -1 shortcuts to 0
  localparam logic signed [9:0] TINY_E = -10'sd1;
`else
  localparam bit              RNE_MODE = 1'b0;
  localparam logic signed [9:0] TINY_E = 10'sd0;
`endif

  typedef enum logic [2:0] {
    WAIT_REQ = 3'd0,
    CHECK    = 3'd1,
    SHIFT    = 3'd2,
    ROUND    = 3'd3,
    PACK     = 3'd4,
    OUT_RDY  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]        r_a;
  logic [31:0]        r_z;
  logic [31:0]        r_zm;
  logic signed [9:0]  r_ze;
  logic               r_guard;
  logic               r_sticky;
  logic               r_nvz;

  logic               w_s;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_e;
  logic [23:0]        w_m;
  logic               w_is_nan;
  logic               w_big;
  logic               w_tiny;
  logic               w_rnd_inc;

  assign w_s       = r_a[31];
  assign w_exp     = r_a[30:23];
  assign w_frac    = r_a[22:0];
  assign w_e       = $signed({2'b00, w_exp}) - 10'sd127;
  assign w_m       = {1'b1, w_frac};
  assign w_is_nan  = (w_exp == 8'hFF) && (w_frac != 23'd0);
  // infinity has e = 128, so it lands here too
  assign w_big     = (w_e > 10'sd30);
  assign w_tiny    = (w_e < TINY_E);
  assign w_rnd_inc = RNE_MODE & r_guard & (r_sticky | r_zm[0]);

  // next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_REQ: if (dval) w_next = CHECK;
      CHECK: begin
        if (w_is_nan || w_big || w_tiny) w_next = OUT_RDY;
        else                             w_next = SHIFT;
      end
      SHIFT:    if (r_ze >= 10'sd31) w_next = ROUND;
      ROUND:    w_next = PACK;
      PACK:     w_next = OUT_RDY;
      OUT_RDY:  w_next = WAIT_REQ;
      default:  w_next = WAIT_REQ;
    endcase
  end

  // control state and registered outputs; reset aborts any conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_REQ;
      rdy     <= 1'b0;
      nv      <= 1'b0;
      result  <= '0;
    end else begin
      r_state <= w_next;
      rdy     <= (r_state == OUT_RDY);
      if (r_state == OUT_RDY) begin
        result <= r_z;
        nv     <= r_nvz;
      end
    end
  end

  // conversion datapath, advanced by the current state
  always_ff @(posedge clk) begin
    unique case (r_state)
      WAIT_REQ: begin
        if (dval) r_a <= din;
      end
      CHECK: begin
        if (w_is_nan) begin
          r_z   <= 32'h7FFF_FFFF;
          r_nvz <= 1'b1;
        end else if (w_big) begin
          if (r_a == 32'hCF00_0000) begin
            // -2^31 is exactly representable
            r_z   <= 32'h8000_0000;
            r_nvz <= 1'b0;
          end else begin
            r_z   <= w_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r_nvz <= 1'b1;
          end
        end else if (w_tiny) begin
          r_z   <= '0;
          r_nvz <= 1'b0;
        end else begin
          r_zm     <= {w_m, 8'h00};
          r_ze     <= w_e;
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
          r_nvz    <= 1'b0;
        end
      end
      SHIFT: begin
        if (r_ze < 10'sd31) begin
          r_zm     <= r_zm >> 1;
          r_guard  <= r_zm[0];
          r_sticky <= r_sticky | r_guard;
          r_ze     <= r_ze + 10'sd1;
        end
      end
      ROUND: begin
        // e <= 30 keeps the magnitude below 2^31, so no carry out
        r_zm <= r_zm + {31'd0, w_rnd_inc};
      end
      PACK: begin
        r_z <= w_s ? (~r_zm + 32'd1) : r_zm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_sp_f2i.sv
// Directed table-driven bench for fpu_sp_f2i; expected values follow the
// build's rounding mode (FPU_F2I_RNE_EN).
module tb_fpu_sp_f2i;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        dval = 1'b0;
  logic [31:0] result;
  logic        rdy;
  logic        nv;

  int n_chk  = 0;
  int n_pass = 0;
  int rdy_pulses = 0;

  localparam int LIMIT = 100;

  typedef struct {
    logic [31:0] d;
    logic [31:0] r;
    logic        v;
    int          lat;
    string       name;
  } vec_t;

  vec_t tv[$];

  fpu_sp_f2i dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .dval   (dval),
    .result (result),
    .rdy    (rdy),
    .nv     (nv)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && rdy) rdy_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] d, input logic [31:0] r, input logic v,
                     input int lat, input string name);
    vec_t t;
    t.d = d; t.r = r; t.v = v; t.lat = lat; t.name = name;
    tv.push_back(t);
  endtask

  // present one request; returns #1 after its sampling edge
  task automatic issue(input logic [31:0] d);
    @(posedge clk); #1;
    din  = d;
    dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
  endtask

  // edges counted from the sampling edge until rdy is seen
  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (rdy !== 1'b1 && lat < LIMIT);
  endtask

  initial begin
    int lat;
    int p0;

    add(32'h4020_0000, 32'h0000_0002, 1'b0, 35, "2.5");
    add(32'h8000_0000, 32'h0000_0000, 1'b0, 2,  "neg0");
    add(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2,  "2^31");
    add(32'hCF00_0000, 32'h8000_0000, 1'b0, 2,  "-2^31");
    add(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 2,  "nan");
    add(32'hFF80_0000, 32'h8000_0000, 1'b1, 2,  "-inf");
    add(32'h3F80_0000, 32'h0000_0001, 1'b0, 36, "1.0");
    add(32'h42F6_0000, 32'h0000_007B, 1'b0, 30, "123.0");
    add(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 6,  "maxfin");
    add(32'h0000_0001, 32'h0000_0000, 1'b0, 2,  "denorm");
`ifdef FPU_F2I_RNE_EN
    add(32'h3FC0_0000, 32'h0000_0002, 1'b0, 36, "1.5");
    add(32'hC030_0000, 32'hFFFF_FFFD, 1'b0, 35, "-2.75");
    add(32'h3F00_0000, 32'h0000_0000, 1'b0, 37, "0.5");
    add(32'h3F40_0000, 32'h0000_0001, 1'b0, 37, "0.75");
    add(32'h4060_0000, 32'h0000_0004, 1'b0, 35, "3.5");
    add(32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 36, "-1.5");
`else
    add(32'h3FC0_0000, 32'h0000_0001, 1'b0, 36, "1.5");
    add(32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 35, "-2.75");
    add(32'h3F00_0000, 32'h0000_0000, 1'b0, 2,  "0.5");
    add(32'h3F40_0000, 32'h0000_0000, 1'b0, 2,  "0.75");
    add(32'h4060_0000, 32'h0000_0003, 1'b0, 35, "3.5");
    add(32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 36, "-1.5");
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",    {31'd0, rdy}, 32'd0);
    chk("rst_nv",     {31'd0, nv},  32'd0);
    chk("rst_result", result,       32'd0);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < tv.size(); i++) begin
      issue(tv[i].d);
      wait_rdy(lat);
      chk({tv[i].name, "_result"}, result, tv[i].r);
      chk({tv[i].name, "_nv"},     {31'd0, nv}, {31'd0, tv[i].v});
      chk({tv[i].name, "_lat"},    lat, tv[i].lat);
      @(posedge clk); #1;
      chk({tv[i].name, "_rdy_w"},  {31'd0, rdy}, 32'd0);
    end

    // busy dval pulses ignored, then back-to-back request in the rdy cycle
    p0 = rdy_pulses;
    issue(32'h4020_0000);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (rdy !== 1'b1) begin
        if (lat == 3 || lat == 10) begin
          din  = 32'h4F00_0000;
          dval = 1'b1;
        end else begin
          dval = 1'b0;
        end
      end
    end while (rdy !== 1'b1 && lat < LIMIT);
    chk("b2b_first_result", result, 32'h0000_0002);
    chk("b2b_first_lat",    lat,    35);
    din  = 32'h3F80_0000;
    dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    chk("b2b_rdy_w", {31'd0, rdy}, 32'd0);
    wait_rdy(lat);
    chk("b2b_second_result", result, 32'h0000_0001);
    chk("b2b_second_lat",    lat,    36);
    repeat (45) @(posedge clk);
    #1;
    chk("b2b_pulses", rdy_pulses - p0, 2);

    // leave nv and result non-zero, then reset mid-shift
    issue(32'h7FC0_0000);
    wait_rdy(lat);
    chk("pre_rst_nv", {31'd0, nv}, 32'd1);
    issue(32'h4020_0000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy",    {31'd0, rdy}, 32'd0);
    chk("midrst_nv",     {31'd0, nv},  32'd0);
    chk("midrst_result", result,       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = rdy_pulses;
    repeat (45) @(posedge clk);
    #1;
    chk("midrst_no_pulse", rdy_pulses - p0, 0);
    chk("midrst_hold",     result,          32'd0);
    issue(32'h42F6_0000);
    wait_rdy(lat);
    chk("post_rst_result", result, 32'h0000_007B);
    chk("post_rst_lat",    lat,    30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
